otter_fetch_unit: RTL and testbench

Instruction-fetch front end for the pipelined OTTER CPU. It owns the program counter and issues word reads to the instruction port of the synchronous memory, which returns data one cycle after the request. Fetched instruction/PC pairs are buffered in a small prefetch queue, and the decode stage consumes them through a valid/ready handshake. Branch and jump redirects from execute flush the queue and discard any read already in flight.

---
 rtl/otter_pkg.sv | 11 +
 rtl/otter_sync_fifo.sv | 49 ++++
 rtl/otter_fetch_unit.sv | 86 ++++++++
 tb/tb_otter_fetch_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER fetch front end.
package otter_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

endpackage

// File: rtl/otter_sync_fifo.sv
// Synchronous FIFO with registered head, occupancy count and synchronous flush.
module otter_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic [63:0],
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          flush,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              head,
    output logic          not_empty,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign do_pop    = pop && (count_q != '0);
    assign do_push   = push && !flush;
    assign head      = mem[rd_ptr_q];
    assign not_empty = (count_q != '0);
    assign count     = count_q;

    always_ff @(posedge CLK) begin
        if (do_push && !RESET) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointers are power-of-two wide, so they wrap without explicit compare.
    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/otter_fetch_unit.sv
// OTTER instruction fetch: PC, single in-flight read tracking and prefetch queue.
module otter_fetch_unit
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    output logic [31:0]              imem_addr,
    output logic                     imem_rd,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     de_ready,
    output logic                     de_valid,
    output logic [31:0]              de_ir,
    output logic [31:0]              de_pc,
    output logic [$clog2(DEPTH):0]   fq_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         inflight_q;
    logic [31:0]  inflight_pc_q;
    logic [31:0]  target;
    logic         room;
    fetch_entry_t push_entry, head_entry;
    logic         fq_push, fq_pop;

    assign target = {redirect_pc[31:2], 2'b00};
    // Counting the in-flight read reserves its slot, so the queue cannot overflow.
    assign room   = ({1'b0, fq_count} + (CW + 1)'(inflight_q)) < (CW + 1)'(DEPTH);

    always_comb begin
        imem_rd    = 1'b0;
        imem_addr  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q;
        if (RESET) begin
            imem_addr = RESET_PC;
        end else if (redirect) begin
            imem_rd    = 1'b1;
            imem_addr  = target;
            fetch_pc_d = target + 32'(INSTR_BYTES);
        end else if (room) begin
            imem_rd    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= imem_rd;
            inflight_pc_q <= imem_addr;
        end
    end

    assign push_entry = '{pc: inflight_pc_q, ir: imem_rdata};
    assign fq_push    = inflight_q && !redirect;
    assign fq_pop     = de_valid && de_ready && !redirect;

    otter_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .flush     (redirect),
        .push      (fq_push),
        .push_data (push_entry),
        .pop       (fq_pop),
        .head      (head_entry),
        .not_empty (de_valid),
        .count     (fq_count)
    );

    assign de_pc = head_entry.pc;
    assign de_ir = head_entry.ir;

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Self-checking bench for otter_fetch_unit: queue-level reference model plus directed literals.
module tb_otter_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RESET, redirect, de_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_rd, de_valid;
    logic [31:0] imem_addr, de_ir, de_pc;
    logic [2:0]  fq_count;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] mem_xor = 32'h0;
    bit          chk_en = 1'b0;

    otter_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .de_ready    (de_ready),
        .de_valid    (de_valid),
        .de_ir       (de_ir),
        .de_pc       (de_pc),
        .fq_count    (fq_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ mem_xor;
    endfunction

    always @(posedge CLK) imem_rdata <= mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    endtask

    // Reference model: queue of {pc, ir} plus one outstanding read.
    logic [31:0] q_pc[$];
    logic [31:0] q_ir[$];
    logic        m_infl = 1'b0;
    logic [31:0] m_infl_pc, m_infl_ir;
    logic [31:0] m_fetch_pc = RESET_PC;

    function automatic logic exp_rd();
        if (RESET) return 1'b0;
        if (redirect) return 1'b1;
        return (q_pc.size() + int'(m_infl)) < int'(DEPTH);
    endfunction

    function automatic logic [31:0] exp_addr();
        if (RESET) return RESET_PC;
        if (redirect) return {redirect_pc[31:2], 2'b00};
        return m_fetch_pc;
    endfunction

    always @(posedge CLK) begin
        logic        rd;
        logic [31:0] a;
        rd = exp_rd();
        a  = exp_addr();
        if (RESET) begin
            q_pc.delete();
            q_ir.delete();
            m_infl     = 1'b0;
            m_fetch_pc = RESET_PC;
        end else begin
            if (redirect) begin
                q_pc.delete();
                q_ir.delete();
            end else begin
                if (q_pc.size() > 0 && de_ready) begin
                    void'(q_pc.pop_front());
                    void'(q_ir.pop_front());
                end
                if (m_infl) begin
                    q_pc.push_back(m_infl_pc);
                    q_ir.push_back(m_infl_ir);
                end
            end
            m_infl    = rd;
            m_infl_pc = a;
            m_infl_ir = mem_word(a);
            if (rd) m_fetch_pc = a + 32'd4;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("imem_rd", 32'(imem_rd), 32'(exp_rd()));
            check("imem_addr", imem_addr, exp_addr());
            check("de_valid", 32'(de_valid), 32'(q_pc.size() > 0));
            check("fq_count", 32'(fq_count), 32'(q_pc.size()));
            if (q_pc.size() > 0) begin
                check("de_pc", de_pc, q_pc[0]);
                check("de_ir", de_ir, q_ir[0]);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
    endtask

    initial begin
        RESET       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        de_ready    = 1'b1;
        step();
        chk_en = 1'b1;
        at_neg();
        check("rst_imem_rd", 32'(imem_rd), 32'd0);
        check("rst_fq_count", 32'(fq_count), 32'd0);
        step();
        RESET = 1'b0;

        // Startup: request in cycle 0, head valid in cycle 2.
        at_neg();
        check("c0_imem_rd", 32'(imem_rd), 32'd1);
        check("c0_imem_addr", imem_addr, RESET_PC);
        step();
        at_neg();
        check("c1_de_valid", 32'(de_valid), 32'd0);
        step();
        at_neg();
        check("c2_de_valid", 32'(de_valid), 32'd1);
        check("c2_de_pc", de_pc, 32'h0);
        check("c2_de_ir", de_ir, 32'h0);
        step();
        at_neg();
        check("c3_de_pc", de_pc, 32'h4);
        repeat (6) step();

        // Stall until full.
        mem_xor  = 32'hA5A5_0000;
        de_ready = 1'b0;
        repeat (10) step();
        at_neg();
        check("stall_count", 32'(fq_count), 32'd4);
        check("stall_rd", 32'(imem_rd), 32'd0);

        // Reach three entries with one read outstanding, then redirect.
        de_ready = 1'b1;
        step();
        de_ready = 1'b0;
        step();
        at_neg();
        check("pre_redir_count", 32'(fq_count), 32'd3);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        de_ready    = 1'b1;
        step();
        redirect = 1'b0;
        at_neg();
        check("redir_count", 32'(fq_count), 32'd0);
        check("redir_valid", 32'(de_valid), 32'd0);
        step();
        at_neg();
        check("redir_pc0", de_pc, 32'h100);
        check("redir_ir0", de_ir, 32'h100 ^ 32'hA5A5_0000);
        step();
        at_neg();
        check("redir_pc1", de_pc, 32'h104);

        // Redirect with a pop, then a second redirect that supersedes it.
        redirect    = 1'b1;
        redirect_pc = 32'h180;
        step();
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        at_neg();
        check("dbl_valid", 32'(de_valid), 32'd0);
        step();
        at_neg();
        check("dbl_pc", de_pc, 32'h200);

        // Unaligned target is forced to word alignment.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0107;
        at_neg();
        check("align_addr", imem_addr, 32'h104);
        step();
        redirect = 1'b0;
        step();
        at_neg();
        check("align_pc", de_pc, 32'h104);

        // PC wraps modulo 2^32.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        step();
        at_neg();
        check("wrap_pc0", de_pc, 32'hFFFF_FFF8);
        step();
        at_neg();
        check("wrap_pc1", de_pc, 32'hFFFF_FFFC);
        step();
        at_neg();
        check("wrap_pc2", de_pc, 32'h0);

        // Reset mid-stream with a full queue.
        de_ready = 1'b0;
        repeat (8) step();
        at_neg();
        check("full_count", 32'(fq_count), 32'd4);
        RESET = 1'b1;
        step();
        at_neg();
        check("mrst_valid", 32'(de_valid), 32'd0);
        check("mrst_count", 32'(fq_count), 32'd0);
        check("mrst_rd", 32'(imem_rd), 32'd0);
        step();
        RESET    = 1'b0;
        de_ready = 1'b1;
        step();
        step();
        at_neg();
        check("restart_valid", 32'(de_valid), 32'd1);
        check("restart_pc", de_pc, RESET_PC);
        repeat (3) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
